data_mem_ctrl: RTL

Multi-cycle controller sitting between the MEM stage and an external 16-bit SRAM that backs the data memory. It translates each 32-bit MEM-stage load/store into two sequenced half-word SRAM accesses with programmable wait states. It drives `ready` low to freeze the pipeline until the word access completes. Data memory address space starts at byte 1024 and is word-addressed: index = (address − 1024) >> 2.

---
 rtl/data_mem_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: bridges a 32-bit MEM-stage load/store onto a 16-bit external SRAM.
// Each word access is split into a low and a high half-word phase. Each phase lasts
// WAIT_CYCLES cycles. The pipeline is frozen (ready=0) until the word completes.
//
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   rd_en, wr_en       - load / store request (held stable while ready=0)
//   address, wdata     - byte address and store data from the MEM stage
//   rdata              - last completed load word
//   ready              - 0 freezes the pipeline
//   sram_addr          - half-word SRAM address {word index, half select}
//   sram_dq_out/_in    - SRAM write / read data
//   sram_dq_oe         - 1 when the controller drives DQ
//   sram_we_n          - SRAM write enable, active-low
module data_mem_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned SRAM_ADDR_W = 18,
  parameter int unsigned WAIT_CYCLES = 5   // legal range 1..15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      address,
  input  logic [WORD_W-1:0]      wdata,
  output logic [WORD_W-1:0]      rdata,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  localparam int unsigned IdxW      = SRAM_ADDR_W - 1;
  localparam logic [3:0]  LastCnt   = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] DmemBase = ADDR_W'(1024);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic [ADDR_W-1:0]   offset;
  logic                req;
  logic                last;
  logic                wr_phase;
  logic                unused_offset_bits;

  // Word index wraps modulo the SRAM size; byte-lane bits are ignored.
  assign offset             = address - DmemBase;
  assign unused_offset_bits = ^{offset[ADDR_W-1:SRAM_ADDR_W+1], offset[1:0]};
  assign req                = rd_en | wr_en;
  assign last               = (cnt_q == LastCnt);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          is_wr_d = wr_en;  // store wins when both are requested
          idx_d   = offset[SRAM_ADDR_W:2];
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = StLow;
        end
      end
      StLow: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StHigh;
          if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHigh: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      // The request still visible here is the one just served; never restart it.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: pure decodes of registered state, so they are stable for a whole phase.
  always_comb begin
    wr_phase    = is_wr_q && ((state_q == StLow) || (state_q == StHigh));
    ready       = (state_q == StDone) || ((state_q == StIdle) && !req);
    sram_addr   = {idx_q, (state_q == StHigh)};
    sram_dq_oe  = wr_phase;
    sram_we_n   = !wr_phase;
    sram_dq_out = '0;
    if (wr_phase) begin
      sram_dq_out = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
    end
  end

  assign rdata = rdata_q;

endmodule
